// File: rtl/data_mem_unit.sv
// Data memory for the MEM stage: byte-lane stores, fixed-latency extended loads,
// and a one-cycle error pulse on misaligned or illegal-code requests.
module data_mem_unit #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    output logic [31:0] DataRd,
    output logic        rd_valid,
    output logic        stall,
    output logic        err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [31:0]   mem_q [DEPTH_WORDS];
    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q;
    logic [2:0]    ctrl_q;
    logic [31:0]   data_q;
    logic          rd_valid_q;
    logic          err_q;

    logic          legal, misaligned, accept, st_wr, ld_acc, bad;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [AW+1:0] rd_addr;
    logic [2:0]    rd_ctrl;
    logic [31:0]   rd_word, rd_shift, rd_ext;
    logic          unused_addr;

    assign unused_addr = ^Address[31:AW+2];

    always_comb begin
        legal = 1'b0;
        case (DMCtrl)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !DMWr;
            default:                legal = 1'b0;
        endcase
    end

    assign misaligned = ((DMCtrl[1:0] == 2'b01) && Address[0]) ||
                        ((DMCtrl[1:0] == 2'b10) && (Address[1:0] != 2'b00));
    assign accept = (state_q == S_IDLE) && req;
    assign st_wr  = accept &&  DMWr && legal && !misaligned;
    assign ld_acc = accept && !DMWr && legal && !misaligned;
    assign bad    = accept && !(legal && !misaligned);

    always_comb begin
        be    = 4'b0000;
        wdata = DataWr;
        case (DMCtrl[1:0])
            2'b00: begin
                be    = 4'b0001 << Address[1:0];
                wdata = {4{DataWr[7:0]}};
            end
            2'b01: begin
                be    = Address[1] ? 4'b1100 : 4'b0011;
                wdata = {2{DataWr[15:0]}};
            end
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && st_wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem_q[Address[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // With zero wait states the response is formed straight from the live request.
    assign rd_addr  = (state_q == S_IDLE) ? Address[AW+1:0] : addr_q;
    assign rd_ctrl  = (state_q == S_IDLE) ? DMCtrl : ctrl_q;
    assign rd_word  = mem_q[rd_addr[AW+1:2]];
    assign rd_shift = rd_word >> {rd_addr[1:0], 3'b000};

    always_comb begin
        case (rd_ctrl)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b100:  rd_ext = {24'h0, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b101:  rd_ext = {16'h0, rd_shift[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ld_acc) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            ctrl_q     <= '0;
            data_q     <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= (state_d == S_RESP);
            err_q      <= bad;
            if (ld_acc) begin
                addr_q <= Address[AW+1:0];
                ctrl_q <= DMCtrl;
            end
            if (state_d == S_RESP) data_q <= rd_ext;
            else if (bad)          data_q <= '0;
        end
    end

    assign DataRd   = data_q;
    assign rd_valid = rd_valid_q;
    assign err      = err_q;
    assign stall    = ld_acc || (state_q == S_WAIT);

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit with WAIT_CYCLES=1 and DEPTH_WORDS=1024.
module tb_data_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        DMWr = 1'b0;
    logic [2:0]  DMCtrl = 3'b000;
    logic [31:0] Address = '0;
    logic [31:0] DataWr = '0;
    logic [31:0] DataRd;
    logic        rd_valid, stall, err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_unit #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .DMWr(DMWr), .DMCtrl(DMCtrl),
        .Address(Address), .DataWr(DataWr), .DataRd(DataRd),
        .rd_valid(rd_valid), .stall(stall), .err(err)
    );

    task automatic run_store(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                             output logic st);
        @(negedge clk);
        req = 1'b1; DMWr = 1'b1; DMCtrl = c; Address = a; DataWr = d;
        #1 st = stall;
    endtask

    task automatic run_load(input logic [2:0] c, input logic [31:0] a,
                            output logic st0, output logic st1, output logic rv1,
                            output logic rv2, output logic st2, output logic [31:0] d,
                            output logic rv3, output logic [31:0] dh);
        @(negedge clk);
        req = 1'b1; DMWr = 1'b0; DMCtrl = c; Address = a;
        #1 st0 = stall;
        @(negedge clk);
        req = 1'b0;
        st1 = stall; rv1 = rd_valid;
        @(negedge clk);
        rv2 = rd_valid; st2 = stall; d = DataRd;
        @(negedge clk);
        rv3 = rd_valid; dh = DataRd;
    endtask

    task automatic run_bad(input logic [2:0] c, input logic [31:0] a, input logic wr,
                           input logic [31:0] d, output logic st, output logic e1,
                           output logic [31:0] d1, output logic e2);
        @(negedge clk);
        req = 1'b1; DMWr = wr; DMCtrl = c; Address = a; DataWr = d;
        #1 st = stall;
        @(negedge clk);
        req = 1'b0;
        e1 = err; d1 = DataRd;
        @(negedge clk);
        e2 = err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0;
        repeat (3) @(negedge clk);
        if ({DataRd, rd_valid, err, stall} !== 35'h0) begin
            $display("FAIL reset got %h/%b/%b/%b exp 0/0/0/0", DataRd, rd_valid, err, stall);
            errors++;
        end
        checks++;
        rst_n = 1'b1;
    endtask

    task automatic test_sw_lw();
        logic st, s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        run_store(3'b010, 32'h10, 32'hDEADBEEF, st);
        if (st !== 1'b0) begin $display("FAIL sw_stall got %b exp 0", st); errors++; end
        checks++;
        run_load(3'b010, 32'h10, s0, s1, v1, v2, s2, d, v3, dh);
        if ({s0, s1, v1} !== 3'b110) begin
            $display("FAIL lw_stall_phase got %b exp 110", {s0, s1, v1}); errors++;
        end
        checks++;
        if ({v2, s2} !== 2'b10) begin $display("FAIL lw_resp got %b exp 10", {v2, s2}); errors++; end
        checks++;
        if (d !== 32'hDEADBEEF) begin $display("FAIL lw_data got %h exp deadbeef", d); errors++; end
        checks++;
        if (v3 !== 1'b0 || dh !== 32'hDEADBEEF) begin
            $display("FAIL lw_hold got %b/%h exp 0/deadbeef", v3, dh); errors++;
        end
        checks++;
    endtask

    task automatic test_reset_in_wait();
        logic s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        logic seen = 1'b0;
        @(negedge clk);
        req = 1'b1; DMWr = 1'b0; DMCtrl = 3'b010; Address = 32'h10;
        @(negedge clk);
        req = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        if ({stall, rd_valid, DataRd} !== 34'h0) begin
            $display("FAIL rst_wait got %b/%b/%h exp 0/0/0", stall, rd_valid, DataRd); errors++;
        end
        checks++;
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            seen |= rd_valid | stall;
        end
        if (seen !== 1'b0) begin $display("FAIL rst_abort got %b exp 0", seen); errors++; end
        checks++;
        run_load(3'b010, 32'h10, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'hDEADBEEF || v2 !== 1'b1) begin
            $display("FAIL rst_keep_mem got %h/%b exp deadbeef/1", d, v2); errors++;
        end
        checks++;
    endtask

    task automatic test_byte_half();
        logic [2:0]  ctl [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b010, 3'b100};
        logic [31:0] adr [8] = '{32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h10, 32'h10, 32'h11};
        logic [31:0] exv [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AD, 32'h000080AD,
                                 32'hFFFFFFEF, 32'hFFFFBEEF, 32'h80ADBEEF, 32'h000000BE};
        logic st, s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        run_store(3'b000, 32'h13, 32'hFFFFFF80, st);
        for (int i = 0; i < 8; i++) begin
            run_load(ctl[i], adr[i], s0, s1, v1, v2, s2, d, v3, dh);
            if (d !== exv[i] || v2 !== 1'b1) begin
                $display("FAIL ld%0d_%b@%h got %h exp %h", i, ctl[i], adr[i], d, exv[i]); errors++;
            end
            checks++;
        end
    endtask

    task automatic test_partial_store();
        logic [2:0]  ctl [4] = '{3'b010, 3'b101, 3'b001, 3'b000};
        logic [31:0] adr [4] = '{32'h14, 32'h16, 32'h14, 32'h14};
        logic [31:0] exv [4] = '{32'h123455AA, 32'h00001234, 32'h000055AA, 32'hFFFFFFAA};
        logic st, s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        run_store(3'b010, 32'h14, 32'hAAAAAAAA, st);
        run_store(3'b001, 32'h16, 32'h99991234, st);
        run_store(3'b000, 32'h15, 32'h77777755, st);
        if (st !== 1'b0) begin $display("FAIL sb_stall got %b exp 0", st); errors++; end
        checks++;
        for (int i = 0; i < 4; i++) begin
            run_load(ctl[i], adr[i], s0, s1, v1, v2, s2, d, v3, dh);
            if (d !== exv[i]) begin
                $display("FAIL part%0d@%h got %h exp %h", i, adr[i], d, exv[i]); errors++;
            end
            checks++;
        end
    endtask

    task automatic test_errors();
        logic [2:0]  ctl [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b110};
        logic [31:0] adr [5] = '{32'h12, 32'h11, 32'h10, 32'h10, 32'h10};
        logic        wrs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic st, e1, e2, s0, s1, v1, v2, s2, v3;
        logic [31:0] d1, d, dh;
        for (int i = 0; i < 5; i++) begin
            run_bad(ctl[i], adr[i], wrs[i], 32'h0000FFFF, st, e1, d1, e2);
            if ({st, e1, e2} !== 3'b010 || d1 !== 32'h0) begin
                $display("FAIL err%0d got st/e1/e2=%b data %h exp 010 data 0", i, {st, e1, e2}, d1);
                errors++;
            end
            checks++;
        end
        run_load(3'b010, 32'h10, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'h80ADBEEF) begin $display("FAIL err_mem got %h exp 80adbeef", d); errors++; end
        checks++;
    endtask

    task automatic test_ignore_busy();
        logic s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        @(negedge clk);
        req = 1'b1; DMWr = 1'b0; DMCtrl = 3'b010; Address = 32'h10;
        @(negedge clk);
        DMWr = 1'b1; DataWr = 32'h0;
        if (stall !== 1'b1) begin $display("FAIL busy_stall got %b exp 1", stall); errors++; end
        checks++;
        @(negedge clk);
        if (rd_valid !== 1'b1 || DataRd !== 32'h80ADBEEF) begin
            $display("FAIL busy_resp got %b/%h exp 1/80adbeef", rd_valid, DataRd); errors++;
        end
        checks++;
        @(negedge clk);
        req = 1'b0;
        run_load(3'b010, 32'h10, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'h80ADBEEF) begin $display("FAIL busy_nowrite got %h exp 80adbeef", d); errors++; end
        checks++;
    endtask

    task automatic test_wrap();
        logic st, s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        run_store(3'b010, 32'h1000, 32'h12345678, st);
        run_load(3'b010, 32'h0, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'h12345678) begin $display("FAIL wrap got %h exp 12345678", d); errors++; end
        checks++;
    endtask

    task automatic test_back_to_back();
        logic st, s0, s1, v1, v2, s2, v3;
        logic [31:0] d, dh;
        run_store(3'b010, 32'h20, 32'hCAFEF00D, st);
        run_load(3'b010, 32'h20, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'hCAFEF00D) begin $display("FAIL b2b_sw got %h exp cafef00d", d); errors++; end
        checks++;
        run_store(3'b000, 32'h21, 32'h00000011, st);
        run_load(3'b100, 32'h21, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'h00000011) begin $display("FAIL b2b_sb got %h exp 00000011", d); errors++; end
        checks++;
        run_load(3'b010, 32'h20, s0, s1, v1, v2, s2, d, v3, dh);
        if (d !== 32'hCAFE110D) begin $display("FAIL b2b_word got %h exp cafe110d", d); errors++; end
        checks++;
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_reset_in_wait();
        test_byte_half();
        test_partial_store();
        test_errors();
        test_ignore_busy();
        test_wrap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
DATA_MEM_UNIT -- requirements
Module: data_mem_unit

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, SHALL set the number of 32-bit memory words; power of two, 16..65536.
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set the extra load wait states, 0..15.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the synchronous, active-low reset.
REQ-005 req  input  1  SHALL flag a valid memory request from the MEM stage this cycle.
REQ-006 DMWr  input  1  SHALL select store (1) or load (0) for the request.
REQ-007 DMCtrl  input  3  SHALL carry the access width/sign code, using RISC-V funct3 encoding.
REQ-008 Address  input  32  SHALL carry the byte address, i.e. ALURes from the MEM stage.
REQ-009 DataWr  input  32  SHALL carry store data, i.e. RUrs2 from the MEM stage.
REQ-010 DataRd  output  32  SHALL carry the extended load result.
REQ-011 rd_valid  output  1  SHALL pulse high for one cycle when DataRd holds a completed load result.
REQ-012 stall  output  1  SHALL request a pipeline freeze while a load is outstanding.
REQ-013 err  output  1  SHALL pulse high for one cycle on a misaligned or illegal-code request.

Function
REQ-014 Word index SHALL be Address[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so accesses wrap.
REQ-015 Legal codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all other codes are illegal.
REQ-016 Misaligned: halfword with Address[0]=1, or word with Address[1:0]!=00; byte accesses are never misaligned.
REQ-017 FSM states SHALL be IDLE, WAIT and RESP; requests are accepted only in IDLE.
REQ-018 IDLE, req=1, DMWr=1, legal and aligned: write the selected bytes at that edge, stay in IDLE, keep stall low; non-selected bytes are unchanged.
REQ-019 SB SHALL write DataWr[7:0] to byte lane Address[1:0]; SH SHALL write DataWr[15:0] to lanes {Address[1],0}/+1; SW SHALL write all four lanes.
REQ-020 IDLE, req=1, DMWr=0, legal and aligned: latch Address and DMCtrl, raise stall in the same cycle (combinational on req), and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-021 WAIT SHALL count down from WAIT_CYCLES, keep stall high, and go to RESP when the count reaches 0.
REQ-022 RESP SHALL drive DataRd and rd_valid=1 for exactly one cycle with stall low, then return to IDLE.
REQ-023 Total load latency from acceptance to rd_valid SHALL be WAIT_CYCLES+1 cycles.
REQ-024 LB/LH SHALL sign-extend the selected byte/halfword, LBU/LHU SHALL zero-extend it, and LW SHALL return the full word.
REQ-025 Misaligned or illegal request in IDLE: no write, no state change, err=1 for the next cycle, DataRd=0, stall low.
REQ-026 req while in WAIT/RESP SHALL be ignored; the pipeline holds its request under stall.
REQ-027 A load to an address stored in the immediately preceding cycle SHALL return the new data (write-before-read).
REQ-028 DataRd SHALL hold its last value when rd_valid=0.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE, wait counter=0, DataRd=0, rd_valid=0, err=0; stall follows as low.
REQ-030 Reset during WAIT/RESP SHALL abort the load without producing rd_valid.
REQ-031 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-032 SW 0xDEADBEEF @0x10, then LW @0x10 with WAIT_CYCLES=1 -> stall high for 2 cycles, rd_valid on the 2nd cycle after acceptance, DataRd=0xDEADBEEF.
REQ-033 SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LH @0x12 -> 0xFFFF80AD.
REQ-034 LW @0x12 or SH @0x11 -> err pulses for 1 cycle, memory unchanged, no stall.
REQ-035 DMCtrl=011 request -> err pulses for 1 cycle, no access.
REQ-036 rst_n low during WAIT -> next cycle IDLE, stall=0, rd_valid never asserts; memory word @0x10 still 0xDEADBEEF.
REQ-037 With DEPTH_WORDS=1024, SW 0x12345678 @0x1000 then LW @0x0 -> 0x12345678 (wrap).
